aud_rec_writer: RTL

- Record-path counterpart of the playback DSP: deserialises left-channel I2S ADC samples from the codec and writes them sequentially into SRAM from address 0.
- Publishes the last written address so the playback path knows where the recording ends.
- Sits between the codec ADC pins and the SRAM arbiter's write port; runs on the codec bit clock.

---
 rtl/aud_rec_writer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/aud_rec_writer.sv
// ---------------------------------------------------------------------------
// aud_rec_writer
//
// Record path of the audio DSP. Deserialises left-channel I2S ADC samples
// (MSB first, one BCLK after the LRCK falling edge) and writes each 16-bit
// word to SRAM. Words go to consecutive addresses, starting from address 0.
// The last written address is published so the playback path knows where
// the recording ends. All logic runs on the rising edge of the codec BCLK.
//
// Optional feature macro: AUD_REC_DECIMATE_EN
//   When defined, only every N-th left sample is stored (N = i_speed, and 0
//   is treated as 1). When undefined, i_speed is ignored and every left
//   sample is written.
//
// Ports:
//   i_clk        codec BCLK
//   i_rst_n      synchronous active-low reset
//   i_start      level, starts a new recording from IDLE
//   i_pause      level, pause while high
//   i_stop       level, abort to IDLE (highest priority)
//   i_speed      decimation factor (optional feature only)
//   i_adclrck    ADC LR clock, 0 = left, 1 = right
//   i_adcdat     ADC serial data, MSB first
//   o_sram_addr  write address
//   o_sram_data  write data
//   o_sram_we    one-cycle registered write strobe
//   o_end_addr   last written address
//   o_has_data   at least one sample written since the last start
//   o_full       recording ended because ADDR_MAX was written
//   o_busy       FSM is not IDLE
// ---------------------------------------------------------------------------
module aud_rec_writer #(
  parameter int unsigned       ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] ADDR_MAX = 20'hFFFFF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [3:0]        i_speed,
  input  logic              i_adclrck,
  input  logic              i_adcdat,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [15:0]       o_sram_data,
  output logic              o_sram_we,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic              o_has_data,
  output logic              o_full,
  output logic              o_busy
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_WRITE,
    S_PAUSE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        prev_lrck;
  logic [3:0]  bit_cnt;
  logic [15:0] shift;
  logic        left_edge;
  logic        last_bit;
  logic        start_rec;
  logic        keep_sample;

  // The left word begins where LRCK falls from right (1) to left (0).
  assign left_edge = prev_lrck & ~i_adclrck;
  // The counter reaches 15 while the 16th data bit is being sampled.
  assign last_bit  = (bit_cnt == 4'd15);
  assign start_rec = (state == S_IDLE) && i_start && !i_stop;
  assign o_busy    = (state != S_IDLE);

`ifdef AUD_REC_DECIMATE_EN
  logic [3:0] dec_cnt;
  logic [3:0] dec_n;

  assign dec_n       = (i_speed == 4'd0) ? 4'd1 : i_speed;
  // The counter is cleared on start, so the first sample after a start is
  // always kept.
  assign keep_sample = (dec_cnt == 4'd0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      dec_cnt <= 4'd0;
    end else if (start_rec) begin
      dec_cnt <= 4'd0;
    end else if (state == S_SHIFT && last_bit && !i_stop) begin
      // The >= compare keeps the counter in range if i_speed drops mid-run.
      dec_cnt <= (dec_cnt >= dec_n - 4'd1) ? 4'd0 : dec_cnt + 4'd1;
    end
  end
`else
  logic unused_speed;
  assign unused_speed = ^i_speed;
  assign keep_sample  = 1'b1;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Priority is stop > pause > start/edge in every state.
  always_comb begin
    // NOTE: a default is assigned first, so no path through the case leaves
    // state_next unassigned and no latch can be inferred.
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (start_rec) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_stop)         state_next = S_IDLE;
        else if (i_pause)   state_next = S_PAUSE;
        else if (left_edge) state_next = S_SHIFT;
      end
      S_SHIFT: begin
        // Pause is deliberately not checked here. A word that has started
        // is finished, and the pause takes effect after it.
        if (i_stop)        state_next = S_IDLE;
        else if (last_bit) state_next = keep_sample ? S_WRITE : S_WAIT;
      end
      S_WRITE: begin
        // The write has already been issued, so a stop here still
        // completes it.
        if (o_sram_addr == ADDR_MAX) state_next = S_IDLE;
        else if (i_stop)             state_next = S_IDLE;
        else if (i_pause)            state_next = S_PAUSE;
        else                         state_next = S_WAIT;
      end
      S_PAUSE: begin
        // Leaving via WAIT means capture restarts on a clean left edge.
        if (i_stop)        state_next = S_IDLE;
        else if (!i_pause) state_next = S_WAIT;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      prev_lrck   <= 1'b1;
      bit_cnt     <= 4'd0;
      shift       <= 16'd0;
      o_sram_addr <= '0;
      o_sram_data <= 16'd0;
      o_sram_we   <= 1'b0;
      o_end_addr  <= '0;
      o_has_data  <= 1'b0;
      o_full      <= 1'b0;
    end else begin
      // NOTE: all sequential state uses non-blocking assignments, so every
      // right-hand side sees the values from before this edge.
      prev_lrck <= i_adclrck;
      // The strobe is high exactly while the FSM sits in WRITE. WRITE never
      // follows WRITE, so the strobe cannot be high two cycles in a row.
      o_sram_we <= (state_next == S_WRITE);

      if (start_rec) begin
        o_sram_addr <= '0;
        o_end_addr  <= '0;
        o_has_data  <= 1'b0;
        o_full      <= 1'b0;
      end

      if (state == S_WAIT && state_next == S_SHIFT) begin
        bit_cnt <= 4'd0;
      end

      if (state == S_SHIFT) begin
        shift   <= {shift[14:0], i_adcdat};
        bit_cnt <= bit_cnt + 4'd1;
      end

      // Present the completed word together with the strobe.
      if (state == S_SHIFT && state_next == S_WRITE) begin
        o_sram_data <= {shift[14:0], i_adcdat};
      end

      if (state == S_WRITE) begin
        o_end_addr <= o_sram_addr;
        o_has_data <= 1'b1;
        if (o_sram_addr == ADDR_MAX) begin
          o_full <= 1'b1;
        end else begin
          o_sram_addr <= o_sram_addr + ADDR_ONE;
        end
      end
    end
  end

endmodule
